// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered, valid/ready instruction decode for the 9-bit
//            accumulator ISA with a one-entry load-use scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int               RADDR_W  = 5,
    parameter int               IMM_W    = 8,
    parameter int               ACC_REG  = 15,
    parameter int               NULL_REG = 16,
    parameter logic [IMM_W-1:0] NOIMM    = IMM_W'(8'hF0),
    parameter int               LOAD_LAT = 2
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               flush,
    input  logic [8:0]         in_inst,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADDR_W-1:0] out_raddr_a,
    output logic [RADDR_W-1:0] out_raddr_b,
    output logic [RADDR_W-1:0] out_waddr,
    output logic [IMM_W-1:0]   out_imm,
    output logic [3:0]         out_class,
    output logic [15:0]        stall_cnt
);

    localparam logic [RADDR_W-1:0] c_acc  = RADDR_W'(ACC_REG);
    localparam logic [RADDR_W-1:0] c_null = RADDR_W'(NULL_REG);
    localparam logic [3:0]         c_lat  = 4'(LOAD_LAT);

    localparam logic [3:0] c_cls_nop    = 4'd0;
    localparam logic [3:0] c_cls_mov    = 4'd1;
    localparam logic [3:0] c_cls_rtype  = 4'd2;
    localparam logic [3:0] c_cls_shifti = 4'd3;
    localparam logic [3:0] c_cls_store  = 4'd4;
    localparam logic [3:0] c_cls_load   = 4'd5;
    localparam logic [3:0] c_cls_branch = 4'd6;
    localparam logic [3:0] c_cls_alui   = 4'd7;
    localparam logic [3:0] c_cls_shiftr = 4'd8;
    localparam logic [3:0] c_cls_cmp    = 4'd9;

    logic [RADDR_W-1:0] w_a, w_b, w_w;
    logic [IMM_W-1:0]   w_imm;
    logic [3:0]         w_cls;
    logic               w_hazard;
    logic               w_accept;
    logic               w_issue;
    logic               w_drain;

    logic               r_valid;
    logic [RADDR_W-1:0] r_a, r_b, r_w;
    logic [IMM_W-1:0]   r_imm;
    logic [3:0]         r_cls;
    logic [RADDR_W-1:0] r_pend_tag;
    logic [3:0]         r_pend_cnt;
    logic [15:0]        r_stall_cnt;

    // casez picks the first matching row, so MOV must precede the 00xx RTYPE row
    always_comb begin
        w_a   = c_null;
        w_b   = c_null;
        w_w   = c_null;
        w_imm = NOIMM;
        w_cls = c_cls_nop;
        casez (in_inst[8:5])
            4'b0000: begin
                w_cls = c_cls_mov;
                w_a   = c_acc;
                w_b   = RADDR_W'(in_inst[4:0]);
                w_w   = RADDR_W'(in_inst[4:0]);
            end
            4'b00??, 4'b1100: begin
                w_cls = c_cls_rtype;
                w_a   = c_acc;
                w_b   = RADDR_W'(in_inst[4:0]);
                w_w   = c_acc;
            end
            4'b010?: begin
                w_cls = c_cls_shifti;
                w_a   = RADDR_W'(in_inst[4:3]);
                w_w   = RADDR_W'(in_inst[4:3]);
                w_imm = IMM_W'(in_inst[2:0]);
            end
            4'b0110: begin
                w_cls = c_cls_store;
                w_a   = RADDR_W'(in_inst[4:1]);
                w_b   = RADDR_W'(in_inst[0]);
            end
            4'b0111: begin
                w_cls = c_cls_load;
                w_b   = RADDR_W'(in_inst[0]);
                w_w   = RADDR_W'(in_inst[4:1]);
            end
            4'b100?: begin
                w_cls = c_cls_branch;
                w_imm = IMM_W'(in_inst[4:0]);
            end
            4'b1101, 4'b1110: begin
                w_cls = c_cls_alui;
                w_a   = c_acc;
                w_w   = c_acc;
                w_imm = IMM_W'(in_inst[4:0]);
            end
            4'b1111: begin
                w_cls = c_cls_shiftr;
                w_a   = RADDR_W'(in_inst[4:3]);
                w_b   = RADDR_W'(in_inst[2:0]);
                w_w   = RADDR_W'(in_inst[4:3]);
            end
            4'b1010: begin
                w_cls = c_cls_cmp;
                w_a   = RADDR_W'(in_inst[4:3]);
                w_b   = RADDR_W'(in_inst[2:0]);
            end
            default: begin
                w_cls = c_cls_nop;
            end
        endcase
    end

    // A second load is held back too, since the scoreboard has only one entry
    assign w_hazard = in_valid && (r_pend_cnt != 4'd0) &&
                      (((w_a != c_null) && (w_a == r_pend_tag)) ||
                       ((w_b != c_null) && (w_b == r_pend_tag)) ||
                       (w_cls == c_cls_load));

    assign w_drain  = ~r_valid | out_ready;
    assign in_ready = ~flush & ~w_hazard & w_drain;
    assign w_accept = in_valid & in_ready;
    assign w_issue  = r_valid & out_ready & (r_cls == c_cls_load);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_a     <= c_null;
            r_b     <= c_null;
            r_w     <= c_null;
            r_imm   <= NOIMM;
            r_cls   <= c_cls_nop;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_a     <= w_a;
            r_b     <= w_b;
            r_w     <= w_w;
            r_imm   <= w_imm;
            r_cls   <= w_cls;
        end else if (flush || out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pend_tag <= c_null;
            r_pend_cnt <= 4'd0;
        end else if (w_issue) begin
            r_pend_tag <= r_w;
            r_pend_cnt <= c_lat;
        end else if (r_pend_cnt != 4'd0) begin
            r_pend_cnt <= r_pend_cnt - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_hazard && w_drain && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign out_valid   = r_valid;
    assign out_raddr_a = r_a;
    assign out_raddr_b = r_b;
    assign out_waddr   = r_w;
    assign out_imm     = r_imm;
    assign out_class   = r_cls;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed plus randomized bench for decode_stage against an
//            instruction-level model of decode, flow control and scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    logic        CLK;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [8:0]  in_inst;
    logic [4:0]  out_raddr_a, out_raddr_b, out_waddr;
    logic [7:0]  out_imm;
    logic [3:0]  out_class;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .CLK(CLK), .reset(reset), .flush(flush),
        .in_inst(in_inst), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_raddr_a(out_raddr_a), .out_raddr_b(out_raddr_b),
        .out_waddr(out_waddr), .out_imm(out_imm), .out_class(out_class),
        .stall_cnt(stall_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct { int a; int b; int w; int imm; int cls; } dec_t;

    // Instruction table: opcode = inst/32, low field = inst%32
    function automatic dec_t ref_decode(input int i);
        dec_t d;
        int op, lo;
        op = i / 32;
        lo = i % 32;
        d = '{a: 16, b: 16, w: 16, imm: 240, cls: 0};
        if (op == 0)                   d = '{15, lo, lo, 240, 1};
        else if (op < 4 || op == 12)   d = '{15, lo, 15, 240, 2};
        else if (op == 4 || op == 5)   d = '{lo / 8, 16, lo / 8, lo % 8, 3};
        else if (op == 6)              d = '{lo / 2, lo % 2, 16, 240, 4};
        else if (op == 7)              d = '{16, lo % 2, lo / 2, 240, 5};
        else if (op == 8 || op == 9)   d = '{16, 16, 16, lo, 6};
        else if (op == 13 || op == 14) d = '{15, 16, 15, lo, 7};
        else if (op == 15)             d = '{lo / 8, lo % 8, lo / 8, 240, 8};
        else if (op == 10)             d = '{lo / 8, lo % 8, 16, 240, 9};
        return d;
    endfunction

    // Model state: the held instruction, the pending load and the stall total
    bit   m_init = 0;
    bit   m_valid;
    dec_t m_out;
    int   m_tag, m_cnt, m_stall;

    always begin
        dec_t d;
        bit   hz, rdy, drain, issue;
        @(negedge CLK);
        #4;
        d     = ref_decode(int'(in_inst));
        drain = !m_valid || out_ready;
        hz    = in_valid && m_cnt != 0 &&
                ((d.a != 16 && d.a == m_tag) || (d.b != 16 && d.b == m_tag) || d.cls == 5);
        rdy   = !flush && !hz && drain;
        if (m_init && !reset) begin
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("raddr_a", int'(out_raddr_a), m_out.a);
            chk("raddr_b", int'(out_raddr_b), m_out.b);
            chk("waddr", int'(out_waddr), m_out.w);
            chk("imm", int'(out_imm), m_out.imm);
            chk("class", int'(out_class), m_out.cls);
            chk("stall_cnt", int'(stall_cnt), m_stall);
            chk("in_ready", int'(in_ready), int'(rdy));
        end
        if (reset) begin
            m_init  = 1;
            m_valid = 0;
            m_out   = '{16, 16, 16, 240, 0};
            m_tag   = 16;
            m_cnt   = 0;
            m_stall = 0;
        end else if (m_init) begin
            issue = m_valid && out_ready && m_out.cls == 5;
            if (hz && drain && m_stall < 65535) m_stall++;
            if (issue) begin
                m_tag = m_out.w;
                m_cnt = 2;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
            if (in_valid && rdy) begin
                m_valid = 1;
                m_out   = d;
            end else if (flush || out_ready) begin
                m_valid = 0;
            end
        end
    end

    initial begin
        int n;
        reset = 1; flush = 0; in_valid = 0; in_inst = 9'h000; out_ready = 1;
        repeat (2) @(negedge CLK);
        reset = 0;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_class", int'(out_class), 0);
        chk("rst_imm", int'(out_imm), 240);
        chk("rst_raddr_a", int'(out_raddr_a), 16);
        chk("rst_waddr", int'(out_waddr), 16);
        chk("rst_stall", int'(stall_cnt), 0);

        // Back-to-back stream
        in_valid = 1; in_inst = 9'h020;
        @(negedge CLK);
        chk("s0_valid", int'(out_valid), 1);
        chk("s0_class", int'(out_class), 2);
        chk("s0_imm", int'(out_imm), 240);
        in_inst = 9'h1A3;
        @(negedge CLK);
        chk("s1_class", int'(out_class), 7);
        chk("s1_imm", int'(out_imm), 3);
        in_inst = 9'h15F;
        @(negedge CLK);
        chk("s2_class", int'(out_class), 9);
        chk("s2_a", int'(out_raddr_a), 3);
        chk("s2_b", int'(out_raddr_b), 7);
        chk("s2_imm", int'(out_imm), 240);

        // Load then dependent, presented after the load has issued
        in_inst = 9'h0E6;
        @(negedge CLK);
        chk("ld_class", int'(out_class), 5);
        chk("ld_waddr", int'(out_waddr), 3);
        in_valid = 0;
        @(negedge CLK);
        in_valid = 1; in_inst = 9'h043;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(out_valid && out_class == 4'd2) && n < 10);
        in_valid = 0;
        chk("dep_latency", n, 3);
        chk("dep_b", int'(out_raddr_b), 3);
        chk("dep_stall", int'(stall_cnt), 2);

        // Independent instruction after a load does not stall
        reset = 1;
        @(negedge CLK);
        reset = 0; in_valid = 1; in_inst = 9'h0E6;
        @(negedge CLK);
        in_valid = 0;
        @(negedge CLK);
        in_valid = 1; in_inst = 9'h044;
        @(negedge CLK);
        in_valid = 0;
        chk("ind_valid", int'(out_valid), 1);
        chk("ind_b", int'(out_raddr_b), 4);
        chk("ind_stall", int'(stall_cnt), 0);

        // Backpressure freezes the output register
        in_valid = 1; in_inst = 9'h1A3;
        @(negedge CLK);
        out_ready = 0; in_inst = 9'h15F;
        repeat (3) begin
            @(negedge CLK);
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_class", int'(out_class), 7);
            chk("bp_imm", int'(out_imm), 3);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", int'(in_ready), 1);
        @(negedge CLK);
        in_valid = 0;
        chk("bp_next_class", int'(out_class), 9);

        // Flush while holding a valid instruction and offering a new one
        in_valid = 1; in_inst = 9'h0E6;
        @(negedge CLK);
        in_inst = 9'h1A3;
        @(negedge CLK);
        out_ready = 0; flush = 1; in_inst = 9'h020;
        @(negedge CLK);
        flush = 0; in_valid = 0; out_ready = 1;
        chk("fl_valid", int'(out_valid), 0);
        chk("fl_class_held", int'(out_class), 7);

        // Reset in the middle of a load stall
        in_valid = 1; in_inst = 9'h0E6;
        @(negedge CLK);
        in_valid = 0;
        @(negedge CLK);
        in_valid = 1; in_inst = 9'h043;
        @(negedge CLK);
        reset = 1;
        @(negedge CLK);
        reset = 0;
        chk("rs_stall", int'(stall_cnt), 0);
        chk("rs_valid", int'(out_valid), 0);
        @(negedge CLK);
        in_valid = 0;
        chk("rs_dep_valid", int'(out_valid), 1);
        chk("rs_dep_class", int'(out_class), 2);

        // Randomized traffic biased toward loads and register readers
        repeat (3000) begin
            int sel;
            sel       = int'($urandom_range(0, 3));
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (sel == 0)      in_inst = {4'b0111, 5'($urandom)};
            else if (sel == 1) in_inst = {4'b0001, 5'($urandom_range(0, 15))};
            else               in_inst = 9'($urandom);
            @(negedge CLK);
        end
        reset = 0; flush = 0; in_valid = 0; out_ready = 1;
        repeat (2) @(negedge CLK);
        #6;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
